alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Two-requester round-robin scheduler that shares a single m_ALU instance.
- Each requester presents an ALU control code and two operands over a valid/ready handshake. The block grants one request at a time, latches its operands, and runs one ALU operation.
- The result and zero flag are returned on a shared response channel tagged with the requester id.
- Sits between issue logic (requesters 0 and 1) and the ALU datapath.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- w_clk  input  1  clock, all state on posedge.
- w_rst  input  1  reset, asynchronous, active-high.
- w_req_valid  input  2  bit i = requester i has a request pending.
- w_req_ready  output  2  bit i = request i accepted this cycle; at most one bit set.
- w_req_ctl0, w_req_ctl1  input  4 each  ALU control code of each requester.
- w_req_a0, w_req_b0, w_req_a1, w_req_b1  input  WIDTH each  operands.
- w_rsp_valid  output  1  response valid.
- w_rsp_ready  input  1  response consumer ready.
- w_rsp_id  output  1  requester the response belongs to.
- w_rsp_data  output  WIDTH  ALU result.
- w_rsp_zero  output  1  result == 0.
- w_rsp_err  output  1  control code was not one of 0,1,2,6,7,12.

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE.
  - w_rsp_valid, w_rsp_id, w_rsp_data, w_rsp_zero and w_rsp_err all go to 0.
  - Latched ctl/operands go to 0.
  - The last-served pointer goes to 1, so requester 0 wins the first tie.
- Reset asserted mid-operation aborts it: no response is produced and the in-flight request is lost.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - w_req_ready is combinational.
  - If only one valid bit is set, that requester is granted.
  - If both are set, grant the requester that is not the last-served pointer.
  - On grant (valid & ready), latch id, ctl, a and b, update the pointer to id, and go to EXEC.
  - With no valid, stay in IDLE.
- EXEC (one cycle):
  - m_ALU evaluates the latched ctl/a/b.
  - Register data, zero and err (err = code not in {0,1,2,6,7,12}; data is 0 in that case, zero = 1).
  - Go to RESP.
- RESP:
  - w_rsp_valid = 1, and all rsp_* outputs are held stable until w_rsp_ready.
  - On w_rsp_valid & w_rsp_ready, clear w_rsp_valid and go to IDLE.
  - w_req_ready = 0 in EXEC and RESP.
- Latency: handshake in cycle T gives w_rsp_valid in cycle T+2. Peak throughput is one operation per 3 cycles when w_rsp_ready is held at 1.
- Arithmetic follows m_ALU: add/sub wrap modulo 2^WIDTH, code 7 is an unsigned compare returning 1 or 0, code 12 is NOR.
- Inputs from the non-granted requester are ignored. It is the requester's duty to hold valid and operands until ready.
- A requester that drops valid before being granted simply loses its slot; no error is raised.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Enabled:
  - Adds outputs w_grant_cnt0 and w_grant_cnt1 (CNT_W each), counting grants per requester. Counters saturate at all-ones and reset to 0.
  - Adds output w_err_cnt (CNT_W), counting responses with err = 1, also saturating.
- Disabled: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared package holds:
  - ALU control code constants: AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12.
  - FSM state encoding: IDLE=0, EXEC=1, RESP=2.
  - A legal-code check function.
- Natural sub-module: the existing m_ALU (WIDTH 32), instantiated once and driven from the latched registers.
- Round-robin grant logic stays inline.

Test Plan:
- Reset then single request: req0 ctl=2, a=5, b=7 handshake at T -> rsp_valid at T+2 with id=0, data=12, zero=0, err=0.
- Simultaneous requests, rsp_ready=1:
  - Setup: req0 ctl=6, a=3, b=3 and req1 ctl=0, a=0xF0, b=0x0F.
  - First: grant 0 -> data=0, zero=1.
  - Next: grant 1 -> data=0, zero=1, id=1.
  - Fairness: alternation continues over 10 operations.
- Backpressure:
  - Setup: rsp_ready=0 for 5 cycles after rsp_valid, with req1 asserted.
  - Response: rsp outputs stay stable, req_ready stays 0, and req1 is granted only in the cycle after the rsp handshake.
- Illegal code: ctl=3, a=1, b=1 -> data=0, zero=1, err=1. With ALU_ARB_STATS_EN, err_cnt increments to 1.
- Wrap and compare:
  - ctl=2, a=0xFFFFFFFF, b=1 -> data=0, zero=1.
  - ctl=7, a=1, b=0xFFFFFFFF -> data=1.
- Reset mid-operation: assert w_rst during EXEC -> rsp_valid stays 0, outputs all 0, next simultaneous request grants requester 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU control codes,
// FSM state encoding and the legal-code check.
package alu_arbiter_pkg;

  localparam logic [3:0] CTL_AND = 4'd0;
  localparam logic [3:0] CTL_OR  = 4'd1;
  localparam logic [3:0] CTL_ADD = 4'd2;
  localparam logic [3:0] CTL_SUB = 4'd6;
  localparam logic [3:0] CTL_SLT = 4'd7;
  localparam logic [3:0] CTL_NOR = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True for the six codes the ALU implements; anything else is flagged as err.
  function automatic logic ctl_legal(input logic [3:0] ctl);
    case (ctl)
      CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_NOR: ctl_legal = 1'b1;
      default:                                             ctl_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// m_ALU datapath: purely combinational. Unknown control codes produce 0,
// which makes zero read 1 for them.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Operation select; add/sub wrap naturally at WIDTH bits, SLT is unsigned.
  always_comb begin
    y = '0;
    case (ctl)
      CTL_AND: y = a & b;
      CTL_OR:  y = a | b;
      CTL_ADD: y = a + b;
      CTL_SUB: y = a - b;
      CTL_SLT: y = (a < b) ? ONE : '0;
      CTL_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sharing one ALU.
// IDLE grants one request and latches it, EXEC registers the ALU result,
// RESP holds the tagged response until the consumer takes it.
// Optional macro ALU_ARB_STATS_EN adds saturating grant/error counters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic [1:0]       w_req_valid,
  output logic [1:0]       w_req_ready,
  input  logic [3:0]       w_req_ctl0,
  input  logic [3:0]       w_req_ctl1,
  input  logic [WIDTH-1:0] w_req_a0,
  input  logic [WIDTH-1:0] w_req_b0,
  input  logic [WIDTH-1:0] w_req_a1,
  input  logic [WIDTH-1:0] w_req_b1,
  output logic             w_rsp_valid,
  input  logic             w_rsp_ready,
  output logic             w_rsp_id,
  output logic [WIDTH-1:0] w_rsp_data,
  output logic             w_rsp_zero,
`ifdef ALU_ARB_STATS_EN
  output logic             w_rsp_err,
  output logic [CNT_W-1:0] w_grant_cnt0,
  output logic [CNT_W-1:0] w_grant_cnt1,
  output logic [CNT_W-1:0] w_err_cnt
`else
  output logic             w_rsp_err
`endif
);

  state_t           state;
  logic             last_id;
  logic             lat_id;
  logic [3:0]       lat_ctl;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic             gnt_id;

  // Round-robin grant: only in IDLE; on a tie the requester not served last wins.
  always_comb begin
    w_req_ready = 2'b00;
    if (state == ST_IDLE) begin
      case (w_req_valid)
        2'b01:   w_req_ready = 2'b01;
        2'b10:   w_req_ready = 2'b10;
        2'b11:   w_req_ready = last_id ? 2'b01 : 2'b10;
        default: w_req_ready = 2'b00;
      endcase
    end
  end

  assign gnt_id = w_req_ready[1];

  alu_arbiter_alu #(.WIDTH(WIDTH)) m_alu (
    .ctl  (lat_ctl),
    .a    (lat_a),
    .b    (lat_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Control FSM with latched request and registered response outputs.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state       <= ST_IDLE;
      last_id     <= 1'b1;
      lat_id      <= 1'b0;
      lat_ctl     <= '0;
      lat_a       <= '0;
      lat_b       <= '0;
      w_rsp_valid <= 1'b0;
      w_rsp_id    <= 1'b0;
      w_rsp_data  <= '0;
      w_rsp_zero  <= 1'b0;
      w_rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|w_req_ready) begin
            lat_id  <= gnt_id;
            lat_ctl <= gnt_id ? w_req_ctl1 : w_req_ctl0;
            lat_a   <= gnt_id ? w_req_a1   : w_req_a0;
            lat_b   <= gnt_id ? w_req_b1   : w_req_b0;
            last_id <= gnt_id;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          w_rsp_id    <= lat_id;
          w_rsp_data  <= alu_y;
          w_rsp_zero  <= alu_zero;
          w_rsp_err   <= ~ctl_legal(lat_ctl);
          w_rsp_valid <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_ready) begin
            w_rsp_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating per-requester grant counters and error-response counter.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_grant_cnt0 <= '0;
      w_grant_cnt1 <= '0;
      w_err_cnt    <= '0;
    end else begin
      if (w_req_ready[0] && w_req_valid[0] && (w_grant_cnt0 != '1))
        w_grant_cnt0 <= w_grant_cnt0 + CNT_ONE;
      if (w_req_ready[1] && w_req_valid[1] && (w_grant_cnt1 != '1))
        w_grant_cnt1 <= w_grant_cnt1 + CNT_ONE;
      if (w_rsp_valid && w_rsp_ready && w_rsp_err && (w_err_cnt != '1))
        w_err_cnt <= w_err_cnt + CNT_ONE;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model checks grants and
// responses every cycle; directed sequences pin hand-computed results.
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             w_clk = 1'b0;
  logic             w_rst = 1'b1;
  logic [1:0]       w_req_valid;
  logic [1:0]       w_req_ready;
  logic [3:0]       w_req_ctl0, w_req_ctl1;
  logic [WIDTH-1:0] w_req_a0, w_req_b0, w_req_a1, w_req_b1;
  logic             w_rsp_valid, w_rsp_ready, w_rsp_id, w_rsp_zero, w_rsp_err;
  logic [WIDTH-1:0] w_rsp_data;
`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] w_grant_cnt0, w_grant_cnt1, w_err_cnt;
`endif

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_req_valid (w_req_valid),
    .w_req_ready (w_req_ready),
    .w_req_ctl0  (w_req_ctl0),
    .w_req_ctl1  (w_req_ctl1),
    .w_req_a0    (w_req_a0),
    .w_req_b0    (w_req_b0),
    .w_req_a1    (w_req_a1),
    .w_req_b1    (w_req_b1),
    .w_rsp_valid (w_rsp_valid),
    .w_rsp_ready (w_rsp_ready),
    .w_rsp_id    (w_rsp_id),
    .w_rsp_data  (w_rsp_data),
    .w_rsp_zero  (w_rsp_zero),
`ifdef ALU_ARB_STATS_EN
    .w_rsp_err    (w_rsp_err),
    .w_grant_cnt0 (w_grant_cnt0),
    .w_grant_cnt1 (w_grant_cnt1),
    .w_err_cnt    (w_err_cnt)
`else
    .w_rsp_err   (w_rsp_err)
`endif
  );

  always #5 w_clk = ~w_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge w_clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got no event want event within bound (t=%0t)", nm, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic             id;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             err;
  } rsp_t;

  function automatic rsp_t ref_rsp(input logic id, input logic [3:0] c,
                                   input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    rsp_t r;
    r.id  = id;
    r.err = 1'b0;
    case (c)
      4'd0:    r.data = a & b;
      4'd1:    r.data = a | b;
      4'd2:    r.data = a + b;
      4'd6:    r.data = a - b;
      4'd7:    r.data = (a < b) ? 1 : 0;
      4'd12:   r.data = ~(a | b);
      default: begin r.data = '0; r.err = 1'b1; end
    endcase
    r.zero = (r.data == '0);
    return r;
  endfunction

  bit         m_busy;
  bit         m_last = 1'b1;
  int         m_age;
  rsp_t       m_q[$];
  logic [1:0] m_rdy;
  bit         m_vld;
  rsp_t       m_g;

  // One outstanding operation at a time; response due two cycles after grant.
  always @(negedge w_clk) begin
    if (w_rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      m_q.delete();
      chk("rst_valid", {63'd0, w_rsp_valid}, 64'd0);
      chk("rst_outs", {29'd0, w_rsp_id, w_rsp_data, w_rsp_zero, w_rsp_err}, 64'd0);
    end else begin
      m_rdy = 2'b00;
      if (!m_busy) begin
        if (w_req_valid == 2'b11)      m_rdy = m_last ? 2'b01 : 2'b10;
        else if (w_req_valid == 2'b01) m_rdy = 2'b01;
        else if (w_req_valid == 2'b10) m_rdy = 2'b10;
      end
      chk("req_ready", {62'd0, w_req_ready}, {62'd0, m_rdy});
      m_vld = m_busy && (m_age >= 2);
      chk("rsp_valid", {63'd0, w_rsp_valid}, {63'd0, m_vld});
      if (m_vld && w_rsp_valid && m_q.size() > 0) begin
        chk("rsp_id",   {63'd0, w_rsp_id},   {63'd0, m_q[0].id});
        chk("rsp_data", {32'd0, w_rsp_data}, {32'd0, m_q[0].data});
        chk("rsp_zero", {63'd0, w_rsp_zero}, {63'd0, m_q[0].zero});
        chk("rsp_err",  {63'd0, w_rsp_err},  {63'd0, m_q[0].err});
        if (w_rsp_ready) begin
          void'(m_q.pop_front());
          m_busy = 1'b0;
        end
      end else if (m_busy) begin
        m_age++;
      end
      if (m_rdy != 2'b00) begin
        m_g = m_rdy[1] ? ref_rsp(1'b1, w_req_ctl1, w_req_a1, w_req_b1)
                       : ref_rsp(1'b0, w_req_ctl0, w_req_a0, w_req_b0);
        m_q.push_back(m_g);
        m_busy = 1'b1;
        m_age  = 1;
        m_last = m_rdy[1];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [3:0] c,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (id == 0) begin
      w_req_ctl0 = c; w_req_a0 = a; w_req_b0 = b; w_req_valid[0] = 1'b1;
    end else begin
      w_req_ctl1 = c; w_req_a1 = a; w_req_b1 = b; w_req_valid[1] = 1'b1;
    end
  endtask

  // Waits for the grant, returns the handshake cycle, drops valid afterwards.
  task automatic wait_grant(input int id, output int hs);
    hs = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge w_clk);
      if (w_req_ready[id]) begin
        hs = cyc;
        break;
      end
    end
    if (hs < 0) timeout($sformatf("grant%0d", id));
    tick();
    w_req_valid[id] = 1'b0;
  endtask

  task automatic do_req(input int id, input logic [3:0] c,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int hs);
    tick();
    set_req(id, c, a, b);
    wait_grant(id, hs);
  endtask

  task automatic expect_rsp(input string nm, input logic id, input logic [WIDTH-1:0] d,
                            input logic z, input logic e, output int rc);
    rc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge w_clk);
      if (w_rsp_valid) begin
        rc = cyc;
        break;
      end
    end
    if (rc < 0) timeout({nm, "_rsp"});
    else begin
      chk({nm, "_id"},   {63'd0, w_rsp_id},   {63'd0, id});
      chk({nm, "_data"}, {32'd0, w_rsp_data}, {32'd0, d});
      chk({nm, "_zero"}, {63'd0, w_rsp_zero}, {63'd0, z});
      chk({nm, "_err"},  {63'd0, w_rsp_err},  {63'd0, e});
    end
  endtask

  task automatic do_reset();
    tick();
    w_rst = 1'b1;
    tick();
    tick();
    w_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequences ----------------
  initial begin
    int hs, rc, got, n, first_c, last_c;
    w_req_valid = 2'b00;
    w_req_ctl0 = '0; w_req_ctl1 = '0;
    w_req_a0 = '0; w_req_b0 = '0; w_req_a1 = '0; w_req_b1 = '0;
    w_rsp_ready = 1'b1;
    repeat (3) @(posedge w_clk);
    #1 w_rst = 1'b0;

    // single request, latency T -> T+2
    do_req(0, 4'd2, 32'd5, 32'd7, hs);
    expect_rsp("t1", 1'b0, 32'd12, 1'b0, 1'b0, rc);
    chk("t1_latency", 64'(rc - hs), 64'd2);

    // simultaneous requests, alternation and 1-per-3-cycles throughput
    do_reset();
    w_req_ctl0 = 4'd6; w_req_a0 = 32'd3;    w_req_b0 = 32'd3;
    w_req_ctl1 = 4'd0; w_req_a1 = 32'hF0;   w_req_b1 = 32'h0F;
    w_req_valid = 2'b11;
    got = 0; n = 0; first_c = 0; last_c = 0;
    while (got < 10 && n < 200) begin
      @(negedge w_clk);
      n++;
      if (w_rsp_valid && w_rsp_ready) begin
        chk($sformatf("t2_id%0d", got), {63'd0, w_rsp_id}, 64'(got % 2));
        chk($sformatf("t2_data%0d", got), {32'd0, w_rsp_data}, 64'd0);
        chk($sformatf("t2_zero%0d", got), {63'd0, w_rsp_zero}, 64'd1);
        if (got == 0) first_c = cyc;
        if (got == 9) last_c = cyc;
        got++;
      end
    end
    tick();
    w_req_valid = 2'b00;
    chk("t2_count", 64'(got), 64'd10);
    chk("t2_throughput", 64'(last_c - first_c), 64'd27);

    // backpressure with req1 waiting
    tick();
    w_rsp_ready = 1'b0;
    do_req(0, 4'd1, 32'hA0, 32'h05, hs);
    set_req(1, 4'd2, 32'd10, 32'd20);
    expect_rsp("t3a", 1'b0, 32'hA5, 1'b0, 1'b0, rc);
    chk("t3_rdy0", {62'd0, w_req_ready}, 64'd0);
    for (int i = 1; i < 5; i++) begin
      @(negedge w_clk);
      chk($sformatf("t3_hold_vld%0d", i), {63'd0, w_rsp_valid}, 64'd1);
      chk($sformatf("t3_hold_data%0d", i), {32'd0, w_rsp_data}, 64'hA5);
      chk($sformatf("t3_hold_rdy%0d", i), {62'd0, w_req_ready}, 64'd0);
    end
    tick();
    w_rsp_ready = 1'b1;
    @(negedge w_clk);
    chk("t3_hs_rdy", {62'd0, w_req_ready}, 64'd0);
    @(negedge w_clk);
    chk("t3_after_rdy", {62'd0, w_req_ready}, 64'd2);
    tick();
    w_req_valid[1] = 1'b0;
    expect_rsp("t3b", 1'b1, 32'd30, 1'b0, 1'b0, rc);

    // illegal code
    do_req(1, 4'd3, 32'd1, 32'd1, hs);
    expect_rsp("t4", 1'b1, 32'd0, 1'b1, 1'b1, rc);
`ifdef ALU_ARB_STATS_EN
    tick();
    chk("t4_err_cnt", {48'd0, w_err_cnt}, 64'd1);
`endif

    // wrap, compare, nor, sub underflow
    do_req(0, 4'd2, 32'hFFFF_FFFF, 32'd1, hs);
    expect_rsp("t5_add_wrap", 1'b0, 32'd0, 1'b1, 1'b0, rc);
    do_req(1, 4'd7, 32'd1, 32'hFFFF_FFFF, hs);
    expect_rsp("t5_slt", 1'b1, 32'd1, 1'b0, 1'b0, rc);
    do_req(0, 4'd7, 32'd5, 32'd3, hs);
    expect_rsp("t5_slt_f", 1'b0, 32'd0, 1'b1, 1'b0, rc);
    do_req(1, 4'd12, 32'd0, 32'h0000_00FF, hs);
    expect_rsp("t5_nor", 1'b1, 32'hFFFF_FF00, 1'b0, 1'b0, rc);
    do_req(0, 4'd6, 32'd0, 32'd1, hs);
    expect_rsp("t5_sub_wrap", 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, rc);

    // reset during EXEC
    do_req(0, 4'd2, 32'd1, 32'd1, hs);
    w_rst = 1'b1;
    @(negedge w_clk);
    chk("t6_rst_outs", {28'd0, w_rsp_valid, w_rsp_id, w_rsp_data, w_rsp_zero, w_rsp_err}, 64'd0);
    tick();
    w_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge w_clk);
      chk($sformatf("t6_novld%0d", i), {63'd0, w_rsp_valid}, 64'd0);
    end
    tick();
    w_req_ctl0 = 4'd0; w_req_a0 = 32'hFF; w_req_b0 = 32'h0F;
    w_req_ctl1 = 4'd1; w_req_a1 = 32'h1;  w_req_b1 = 32'h2;
    w_req_valid = 2'b11;
    @(negedge w_clk);
    chk("t6_first_gnt", {62'd0, w_req_ready}, 64'd1);
    tick();
    w_req_valid = 2'b00;
    expect_rsp("t6", 1'b0, 32'h0F, 1'b0, 1'b0, rc);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
